// File: rtl/intersection_phase_scheduler.sv
// Round-robin right-of-way sequencer for an N-approach intersection.
// Define PREEMPT_EN to add emergency-vehicle preemption inputs.
module intersection_phase_scheduler #(
  parameter int N_APPR       = 4,
  parameter int GREEN_MIN    = 10,
  parameter int GREEN_MAX    = 30,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int DEFAULT_APPR = 0,
  parameter int CNT_W        = 8,
  localparam int IDX_W       = $clog2(N_APPR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_APPR-1:0]   req,
  input  logic                ext,
`ifdef PREEMPT_EN
  input  logic                preempt,
  input  logic [IDX_W-1:0]    preempt_idx,
`endif
  output logic [2*N_APPR-1:0] lights,
  output logic [IDX_W-1:0]    green_idx,
  output logic [1:0]          phase,
  output logic [N_APPR-1:0]   pending
);

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_t;

  localparam logic [IDX_W-1:0] IDX_DEF  = IDX_W'(DEFAULT_APPR);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_APPR - 1);

  phase_t              phase_q, phase_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [N_APPR-1:0]   pend_q, pend_d;
  logic [N_APPR-1:0]   grant_mask;

  logic                scan_hit;
  logic [IDX_W-1:0]    scan_idx;
  int                  pos;

  logic                min_ok;
  logic                max_ok;
  logic                green_exit;

  // State register: phase, timer, grant, round-robin pointer, request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_RED;
      timer_q <= '0;
      idx_q   <= IDX_DEF;
      ptr_q   <= IDX_DEF;
      pend_q  <= '0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // First pending approach at or after the round-robin pointer
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = ptr_q;
    pos      = 0;
    for (int i = 0; i < N_APPR; i++) begin
      pos = (int'(ptr_q) + i) % N_APPR;
      if (!scan_hit && pend_q[pos]) begin
        scan_hit = 1'b1;
        scan_idx = IDX_W'(pos);
      end
    end
  end

  // Green exit decision; preemption overrides the min/max/extension rules
  always_comb begin
    min_ok     = timer_q >= CNT_W'(GREEN_MIN - 1);
    max_ok     = timer_q >= CNT_W'(GREEN_MAX - 1);
    green_exit = (|pend_q) && min_ok && (!ext || max_ok);
`ifdef PREEMPT_EN
    if (preempt)
      green_exit = (preempt_idx != idx_q);
`endif
  end

  // Next-state: phase sequencing, grant selection, request latch, timer
  always_comb begin
    phase_d    = phase_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    grant_mask = '0;
    if (phase_q != PH_RED)
      grant_mask[idx_q] = 1'b1;
    pend_d = pend_q | (req & ~grant_mask);
    unique case (phase_q)
      PH_RED: begin
        if (timer_q == CNT_W'(ALLRED_T - 1)) begin
          phase_d = PH_GREEN;
`ifdef PREEMPT_EN
          if (preempt) begin
            idx_d = preempt_idx;
          end else if (scan_hit) begin
            idx_d = scan_idx;
            ptr_d = (scan_idx == IDX_LAST) ? '0
                  : scan_idx + IDX_W'(1);
          end
`else
          if (scan_hit) begin
            idx_d = scan_idx;
            ptr_d = (scan_idx == IDX_LAST) ? '0
                  : scan_idx + IDX_W'(1);
          end
`endif
          pend_d[idx_d] = 1'b0;
        end
      end
      PH_GREEN: begin
        if (green_exit)
          phase_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (timer_q == CNT_W'(YELLOW_T - 1))
          phase_d = PH_RED;
      end
      default: phase_d = PH_RED;
    endcase
    if (phase_d != phase_q)
      timer_d = '0;
    else if (timer_q == {CNT_W{1'b1}})
      timer_d = timer_q;
    else
      timer_d = timer_q + CNT_W'(1);
  end

  // Outputs decoded from registered state only
  always_comb begin
    lights = '0;
    unique case (phase_q)
      PH_GREEN:  lights[2*idx_q +: 2] = 2'b10;
      PH_YELLOW: lights[2*idx_q +: 2] = 2'b01;
      default:   lights = '0;
    endcase
    green_idx = idx_q;
    phase     = phase_q;
    pending   = pend_q;
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler.
// Build with PREEMPT_EN defined to also exercise preemption.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       ext = 1'b0;
`ifdef PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_idx = '0;
`endif
  logic [7:0] lights;
  logic [1:0] green_idx;
  logic [1:0] phase;
  logic [3:0] pending;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .N_APPR(4),
    .GREEN_MIN(4),
    .GREEN_MAX(8),
    .YELLOW_T(2),
    .ALLRED_T(1),
    .DEFAULT_APPR(0),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .ext(ext),
`ifdef PREEMPT_EN
    .preempt(preempt),
    .preempt_idx(preempt_idx),
`endif
    .lights(lights),
    .green_idx(green_idx),
    .phase(phase),
    .pending(pending)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    // 1: reset, one all-red cycle, then default green held
    rst = 1'b0;
    step(2);
    chk("rst_lights", lights, 8'h00);
    chk("rst_phase", {6'd0, phase}, 8'h00);
    chk("rst_idx", {6'd0, green_idx}, 8'h00);
    chk("rst_pend", {4'd0, pending}, 8'h00);
    rst = 1'b1;
    chk("rel_allred", lights, 8'h00);
    step();
    chk("first_green", lights, 8'h02);
    chk("first_phase", {6'd0, phase}, 8'h01);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("hold_green", lights, 8'h02);
    end

    // 2: single request for approach 2
    do_reset();
    step();
    step();
    req = 4'b0100;
    step();
    req = '0;
    chk("t2_pend", {4'd0, pending}, 8'h04);
    step();
    chk("t2_green_t3", lights, 8'h02);
    step();
    chk("t2_yel0", lights, 8'h01);
    chk("t2_yel_ph", {6'd0, phase}, 8'h02);
    step();
    chk("t2_yel1", lights, 8'h01);
    step();
    chk("t2_allred", lights, 8'h00);
    chk("t2_ar_ph", {6'd0, phase}, 8'h00);
    step();
    chk("t2_g2", lights, 8'h20);
    chk("t2_g2_pend", {4'd0, pending}, 8'h00);
    chk("t2_g2_idx", {6'd0, green_idx}, 8'h02);

    // 3: two requests served round-robin
    do_reset();
    step();
    req = 4'b1010;
    step();
    req = '0;
    chk("t3_pend", {4'd0, pending}, 8'h0a);
    step(3);
    chk("t3_yel0", lights, 8'h01);
    step(2);
    chk("t3_allred", lights, 8'h00);
    step();
    chk("t3_g1", lights, 8'h08);
    chk("t3_g1_pend", {4'd0, pending}, 8'h08);
    chk("t3_g1_idx", {6'd0, green_idx}, 8'h01);
    step(4);
    chk("t3_yel1", lights, 8'h04);
    step(2);
    chk("t3_allred2", lights, 8'h00);
    step();
    chk("t3_g3", lights, 8'h80);
    chk("t3_g3_pend", {4'd0, pending}, 8'h00);
    step(20);
    chk("t3_g3_hold", lights, 8'h80);
    chk("t3_g3_ph", {6'd0, phase}, 8'h01);

    // 4a: extension held runs to maximum green
    do_reset();
    step();
    ext = 1'b1;
    req = 4'b0010;
    step();
    req = '0;
    step(6);
    chk("t4_ext_t7", lights, 8'h02);
    step();
    chk("t4_ext_yel", lights, 8'h01);
    step(3);
    chk("t4_ext_g1", lights, 8'h08);
    ext = 1'b0;

    // 4b: extension dropped at green cycle 5
    do_reset();
    step();
    ext = 1'b1;
    req = 4'b0010;
    step();
    req = '0;
    step(4);
    ext = 1'b0;
    chk("t4_drop_t5", lights, 8'h02);
    step();
    chk("t4_drop_yel", lights, 8'h01);
    step(3);
    chk("t4_drop_g1", lights, 8'h08);
    chk("t4_drop_idx", {6'd0, green_idx}, 8'h01);

    // served approach's own request is dropped
    req = 4'b0010;
    step();
    req = '0;
    chk("self_req_drop", {4'd0, pending}, 8'h00);

    // late request: one cycle to latch, one to exit
    step(10);
    req = 4'b1000;
    step();
    req = '0;
    chk("late_pend", {4'd0, pending}, 8'h08);
    chk("late_still_g", lights, 8'h08);
    step();
    chk("late_yel", lights, 8'h04);

    // 5: asynchronous reset mid-yellow
    rst = 1'b0;
    #1;
    chk("async_lights", lights, 8'h00);
    chk("async_pend", {4'd0, pending}, 8'h00);
    chk("async_phase", {6'd0, phase}, 8'h00);
    chk("async_idx", {6'd0, green_idx}, 8'h00);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_g0", lights, 8'h02);

`ifdef PREEMPT_EN
    // 6: preemption to approach 3 with approach 1 pending
    req = 4'b0010;
    step();
    req = '0;
    preempt = 1'b1;
    preempt_idx = 2'd3;
    step();
    chk("pre_yel0", lights, 8'h01);
    step();
    chk("pre_yel1", lights, 8'h01);
    step();
    chk("pre_allred", lights, 8'h00);
    step();
    chk("pre_g3", lights, 8'h80);
    chk("pre_g3_pend", {4'd0, pending}, 8'h02);
    step(15);
    chk("pre_g3_hold", lights, 8'h80);
    preempt = 1'b0;
    step();
    chk("pre_yel3", lights, 8'h40);
    step(2);
    chk("pre_allred2", lights, 8'h00);
    step();
    chk("pre_g1", lights, 8'h08);
    chk("pre_g1_pend", {4'd0, pending}, 8'h00);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences right-of-way for an N-approach intersection, using the same 2-bit light encoding as the two-road traffic controller.
- Latches vehicle-detector requests per approach and grants green round-robin.
- Enforces minimum green, optional extension up to a maximum green, a fixed yellow time, and an all-red clearance time.
- Sits above the per-approach light drivers. It is the single authority on which approach may be green.

Parameters:
- N_APPR, 4: number of approaches; IDX_W = $clog2(N_APPR) is a derived localparam.
- GREEN_MIN, 10: minimum green duration in clk cycles; must be >= 1.
- GREEN_MAX, 30: maximum green duration while extension is requested; must be >= GREEN_MIN.
- YELLOW_T, 3: yellow duration in cycles; must be >= 1.
- ALLRED_T, 2: all-red clearance duration in cycles; must be >= 1.
- DEFAULT_APPR, 0: approach granted green after reset when nothing is pending; must be < N_APPR.
- CNT_W, 8: phase timer width; must hold GREEN_MAX.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- req, input, N_APPR: per-approach detector request; level or pulse.
- ext, input, 1: green-extension request from the detector of the currently green approach.
- lights, output, 2*N_APPR: light state per approach; bits [2i+1:2i] belong to approach i; 00=RED, 01=YELLOW, 10=GREEN; 11 is never driven.
- green_idx, output, IDX_W: approach currently granted (green or yellow).
- phase, output, 2: 00=ALL_RED, 01=GREEN, 10=YELLOW.
- pending, output, N_APPR: latched, unserved requests.

Behaviour:
- Reset (rst=0, asynchronous, effective mid-operation):
  - phase=ALL_RED, lights all 00, green_idx=DEFAULT_APPR, pending=0.
  - Phase timer=0; round-robin pointer ptr=DEFAULT_APPR.
- Request latch:
  - Each cycle: pending <= pending | (req & ~grant_mask).
  - grant_mask = onehot(green_idx) when phase is GREEN or YELLOW, else 0. Requests from the served approach are therefore dropped.
  - A pending bit clears in the cycle that approach enters GREEN. If req is set in that same cycle, the clear wins.
- Timer: resets to 0 on every phase change, otherwise increments. It saturates at all-ones and never wraps.
- ALL_RED:
  - Lasts exactly ALLRED_T cycles.
  - On the edge where timer==ALLRED_T-1, choose the first set pending bit scanning ptr, ptr+1, ... (mod N_APPR).
  - Then: green_idx <= chosen; ptr <= chosen+1 (mod N_APPR); phase <= GREEN.
  - If pending==0, grant green_idx (unchanged; DEFAULT_APPR after reset) and leave ptr unchanged.
- GREEN (lights[green_idx]=10, all others 00):
  - Exit to YELLOW on the edge where pending!=0, timer>=GREEN_MIN-1, and (ext==0 or timer>=GREEN_MAX-1).
  - With pending==0, green holds indefinitely; ext is ignored.
  - A request arriving after GREEN_MIN has elapsed with ext=0 causes exit on the next edge: one cycle to latch, one to exit.
- YELLOW (lights[green_idx]=01):
  - Lasts exactly YELLOW_T cycles, then ALL_RED.
  - Cannot be aborted except by reset.
- Invariant: at most one approach is non-RED at any time. Outputs are registered, with no combinational path from input to output.

Optional Feature:
- Macro PREEMPT_EN adds two inputs: preempt (1) and preempt_idx (IDX_W). These model an emergency vehicle.
- With PREEMPT_EN defined, while preempt=1:
  - GREEN with green_idx==preempt_idx: hold green, ignoring GREEN_MAX.
  - GREEN on another approach: go to YELLOW on the next edge, ignoring GREEN_MIN and ext.
  - ALL_RED exit: grant preempt_idx regardless of pending and ptr; ptr is unchanged. Its pending bit clears if set.
  - The YELLOW and ALL_RED durations are always honoured.
- Without PREEMPT_EN: the ports are absent and behaviour is exactly as above.

Test Plan (GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, N_APPR=4, DEFAULT_APPR=0):
1. Hold rst=0 for 2 cycles, release with req=0 → lights=8'h00 for 1 cycle, then lights=8'b00_00_00_10 and phase=01, held for 40 cycles.
2. Pulse req[2] one cycle at green cycle 1 → pending=4'b0100; approach 0 green 4 cycles, yellow (8'b00_00_00_01) 2 cycles, all-red 1 cycle; then lights=8'b00_10_00_00 and pending=0.
3. While approach 0 green, req=4'b1010 for one cycle → approach 1 served, then approach 3; approach 3 then stays green with no pending.
4. req[1] pending and ext=1 held → approach 0 green for exactly 8 cycles. Repeat, dropping ext at green cycle 5 → exit on the next qualifying edge, green lasts 6 cycles.
5. Assert rst mid-YELLOW with pending=4'b1000 → lights=8'h00, pending=0, phase=00 immediately, before the next clk edge.
6. With PREEMPT_EN defined: preempt=1, preempt_idx=3 at approach 0 green cycle 1 while pending=4'b0010 → yellow 2 cycles, all-red 1 cycle, approach 3 green held while preempt=1; pending[1] retained and served after preempt drops.
